// File: rtl/adder_bcd_pkg.sv
// rtl/adder_bcd_pkg.sv - shared types, segment constants and sizing helper for the BCD adder display
package adder_bcd_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        CONV = 1'b1
    } state_e;

    localparam logic [6:0] SEG_BLANK = 7'h7F;
    localparam logic [6:0] SEG_0     = 7'b1000000;
    localparam logic [6:0] SEG_1     = 7'b1111001;
    localparam logic [6:0] SEG_2     = 7'b0100100;
    localparam logic [6:0] SEG_3     = 7'b0110000;
    localparam logic [6:0] SEG_4     = 7'b0011001;
    localparam logic [6:0] SEG_5     = 7'b0010010;
    localparam logic [6:0] SEG_6     = 7'b0000010;
    localparam logic [6:0] SEG_7     = 7'b1111000;
    localparam logic [6:0] SEG_8     = 7'b0000000;
    localparam logic [6:0] SEG_9     = 7'b0010000;

    // BCD bits needed to hold the largest (w+1)-bit sum, 2^(w+1)-1
    function automatic int bcd_width(input int w);
        longint unsigned maxv;
        int digits;
        maxv   = (64'd1 << (w + 1)) - 64'd1;
        digits = 1;
        for (int i = 0; i < 20; i++) begin
            if (maxv >= 64'd10) begin
                maxv   = maxv / 64'd10;
                digits = digits + 1;
            end
        end
        return 4 * digits;
    endfunction

endpackage

// File: rtl/bcd_seg_decode.sv
// rtl/bcd_seg_decode.sv - combinational BCD digit to active-low seven-segment decoder
module bcd_seg_decode
    import adder_bcd_pkg::*;
(
    input  logic [3:0] bcd_i,
    input  logic       blank_i,
    output logic [6:0] seg_n_o
);

    always_comb begin
        seg_n_o = SEG_BLANK;
        if (!blank_i) begin
            case (bcd_i)
                4'd0:    seg_n_o = SEG_0;
                4'd1:    seg_n_o = SEG_1;
                4'd2:    seg_n_o = SEG_2;
                4'd3:    seg_n_o = SEG_3;
                4'd4:    seg_n_o = SEG_4;
                4'd5:    seg_n_o = SEG_5;
                4'd6:    seg_n_o = SEG_6;
                4'd7:    seg_n_o = SEG_7;
                4'd8:    seg_n_o = SEG_8;
                4'd9:    seg_n_o = SEG_9;
                default: seg_n_o = SEG_BLANK;
            endcase
        end
    end

endmodule

// File: rtl/adder_bcd_scan_display.sv
// rtl/adder_bcd_scan_display.sv - W-bit adder, double-dabble BCD converter, scanned 7-seg driver
// Optional: LEADING_ZERO_BLANK_EN blanks digits above the most significant nonzero digit.
module adder_bcd_scan_display
    import adder_bcd_pkg::*;
#(
    parameter int W        = 4,
    parameter int DIGITS   = 2,
    parameter int SCAN_DIV = 50000
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [W-1:0]      din_a,
    input  logic [W-1:0]      din_b,
    input  logic              load,
    output logic              busy,
    output logic              done,
    output logic [6:0]        seg_n,
    output logic              dp_n,
    output logic [DIGITS-1:0] an_n
);

    localparam int BW = bcd_width(W);
    localparam int DW = 4 * DIGITS;
    localparam int IW = (DIGITS > 1) ? $clog2(DIGITS) : 1;
    localparam int PW = $clog2(SCAN_DIV);
    localparam int CW = $clog2(W + 2);

    state_e            state_q, state_d;
    logic [W:0]        bin_q, bin_d;
    logic [BW-1:0]     bcd_q, bcd_d;
    logic [BW-1:0]     bcd_adj, bcd_shift;
    logic [CW-1:0]     cnt_q, cnt_d;
    logic              busy_q, busy_d;
    logic              done_q, done_d;
    logic [DW-1:0]     disp_q, disp_d;
    logic [PW-1:0]     presc_q, presc_d;
    logic [IW-1:0]     idx_q, idx_d;
    logic [6:0]        seg_n_q, seg_n_d;
    logic [DIGITS-1:0] an_n_q, an_n_d;
    logic [3:0]        digit;
    logic              blank;

    always_comb begin
        bcd_adj = bcd_q;
        for (int i = 0; i < BW / 4; i++) begin
            if (bcd_q[4*i +: 4] >= 4'd5) begin
                bcd_adj[4*i +: 4] = bcd_q[4*i +: 4] + 4'd3;
            end
        end
        bcd_shift = (bcd_adj << 1) | {{(BW-1){1'b0}}, bin_q[W]};
    end

    always_comb begin
        state_d = state_q;
        bin_d   = bin_q;
        bcd_d   = bcd_q;
        cnt_d   = cnt_q;
        busy_d  = busy_q;
        done_d  = 1'b0;
        disp_d  = disp_q;
        case (state_q)
            IDLE: begin
                if (load) begin
                    bin_d   = {1'b0, din_a} + {1'b0, din_b};
                    bcd_d   = '0;
                    cnt_d   = CW'(W + 1);
                    busy_d  = 1'b1;
                    state_d = CONV;
                end
            end
            CONV: begin
                bcd_d = bcd_shift;
                bin_d = bin_q << 1;
                cnt_d = cnt_q - 1'b1;
                // Final iteration publishes straight to the display so partial results never show
                if (cnt_q == CW'(1)) begin
                    disp_d  = DW'(bcd_shift);
                    done_d  = 1'b1;
                    busy_d  = 1'b0;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        presc_d = presc_q + 1'b1;
        idx_d   = idx_q;
        if (presc_q == PW'(SCAN_DIV - 1)) begin
            presc_d = '0;
            idx_d   = (idx_q == IW'(DIGITS - 1)) ? '0 : idx_q + 1'b1;
        end
        digit = disp_q[4*idx_q +: 4];
`ifdef LEADING_ZERO_BLANK_EN
        blank = (idx_q != '0) && ((disp_q >> (4 * idx_q)) == '0);
`else
        blank = 1'b0;
`endif
        an_n_d = ~(DIGITS'(1) << idx_q);
    end

    bcd_seg_decode u_decode (
        .bcd_i   (digit),
        .blank_i (blank),
        .seg_n_o (seg_n_d)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= IDLE;
            bin_q   <= '0;
            bcd_q   <= '0;
            cnt_q   <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            disp_q  <= '0;
            presc_q <= '0;
            idx_q   <= '0;
            seg_n_q <= SEG_0;
            an_n_q  <= ~DIGITS'(1);
        end else begin
            state_q <= state_d;
            bin_q   <= bin_d;
            bcd_q   <= bcd_d;
            cnt_q   <= cnt_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            disp_q  <= disp_d;
            presc_q <= presc_d;
            idx_q   <= idx_d;
            seg_n_q <= seg_n_d;
            an_n_q  <= an_n_d;
        end
    end

    assign busy  = busy_q;
    assign done  = done_q;
    assign seg_n = seg_n_q;
    assign an_n  = an_n_q;
    assign dp_n  = 1'b1;

endmodule

// File: tb/tb_adder_bcd_scan_display.sv
// tb/tb_adder_bcd_scan_display.sv - directed self-checking bench for adder_bcd_scan_display
module tb_adder_bcd_scan_display;

    localparam int W        = 4;
    localparam int DIGITS   = 2;
    localparam int SCAN_DIV = 4;

    localparam logic [6:0] S0 = 7'b1000000;
    localparam logic [6:0] S1 = 7'b1111001;
    localparam logic [6:0] S3 = 7'b0110000;
    localparam logic [6:0] S5 = 7'b0010010;
    localparam logic [6:0] S7 = 7'b1111000;
`ifdef LEADING_ZERO_BLANK_EN
    localparam logic [6:0] LEAD0 = 7'h7F;
`else
    localparam logic [6:0] LEAD0 = 7'b1000000;
`endif

    logic              clk = 1'b0;
    logic              rst_n;
    logic [W-1:0]      din_a, din_b;
    logic              load;
    logic              busy, done, dp_n;
    logic [6:0]        seg_n;
    logic [DIGITS-1:0] an_n;

    int checks = 0;
    int errors = 0;
    int dones;

    always #5 clk = ~clk;

    adder_bcd_scan_display #(.W(W), .DIGITS(DIGITS), .SCAN_DIV(SCAN_DIV)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .din_a (din_a),
        .din_b (din_b),
        .load  (load),
        .busy  (busy),
        .done  (done),
        .seg_n (seg_n),
        .dp_n  (dp_n),
        .an_n  (an_n)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic show(input string tag, input logic [1:0] an_exp, input logic [6:0] seg_exp);
        int n = 0;
        while (an_n !== an_exp && n < 20) begin
            tick();
            n++;
        end
        check({tag, "_an"}, 32'(an_n), 32'(an_exp));
        check({tag, "_seg"}, 32'(seg_n), 32'(seg_exp));
    endtask

    task automatic start(input logic [W-1:0] a, input logic [W-1:0] b);
        din_a = a;
        din_b = b;
        load  = 1'b1;
        tick();
        load  = 1'b0;
    endtask

    task automatic run_count(input int cycles);
        for (int i = 0; i < cycles; i++) begin
            tick();
            if (done === 1'b1) dones++;
        end
    endtask

    initial begin
        rst_n = 1'b0;
        din_a = '0;
        din_b = '0;
        load  = 1'b0;
        tick();
        tick();
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        check("rst_an", 32'(an_n), 32'b10);
        check("rst_seg", 32'(seg_n), 32'(S0));
        check("rst_dp", 32'(dp_n), 32'd1);
        rst_n = 1'b1;
        for (int i = 0; i < 4; i++) tick();
        check("scan_hold", 32'(an_n), 32'b10);
        tick();
        check("scan_step", 32'(an_n), 32'b01);

        // 9 + 8 = 17, busy for exactly five cycles
        start(4'd9, 4'd8);
        check("add_busy0", 32'(busy), 32'd1);
        for (int i = 1; i < 5; i++) begin
            tick();
            check("add_busy", 32'(busy), 32'd1);
            check("add_nodone", 32'(done), 32'd0);
        end
        tick();
        check("add_busy_end", 32'(busy), 32'd0);
        check("add_done", 32'(done), 32'd1);
        tick();
        check("add_done_pulse", 32'(done), 32'd0);
        show("add17_d0", 2'b10, S7);
        show("add17_d1", 2'b01, S1);

        // 15 + 15 = 30, carry into bit W
        start(4'd15, 4'd15);
        run_count(7);
        show("add30_d0", 2'b10, S0);
        show("add30_d1", 2'b01, S3);

        // load during busy is ignored
        dones = 0;
        start(4'd9, 4'd8);
        tick();
        din_a = 4'd1;
        din_b = 4'd1;
        load  = 1'b1;
        tick();
        load  = 1'b0;
        run_count(12);
        check("ignore_dones", 32'(dones), 32'd1);
        check("ignore_busy", 32'(busy), 32'd0);
        show("ignore_d0", 2'b10, S7);
        show("ignore_d1", 2'b01, S1);

        // reset in third busy cycle aborts
        dones = 0;
        start(4'd15, 4'd15);
        tick();
        tick();
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        check("abort_busy", 32'(busy), 32'd0);
        check("abort_an", 32'(an_n), 32'b10);
        check("abort_seg", 32'(seg_n), 32'(S0));
        run_count(10);
        check("abort_dones", 32'(dones), 32'd0);
        show("abort_d1", 2'b01, LEAD0);

        // 2 + 3 = 5, leading digit zero
        start(4'd2, 4'd3);
        run_count(7);
        show("five_d0", 2'b10, S5);
        show("five_d1", 2'b01, LEAD0);
        check("dp_const", 32'(dp_n), 32'd1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/adder_bcd_scan_display.md
Name: adder_bcd_scan_display

Overview:
- Parametrised successor to the two-digit adder/seven-segment display block.
- Adds two W-bit operands on a load strobe and converts the (W+1)-bit sum to BCD with a sequential shift-add-3 (double-dabble) engine.
- Drives DIGITS multiplexed seven-segment digits through a scan prescaler.
- Sits between the board switch/button inputs and the shared-segment display pins.

Parameters:
- W, 4, operand width in bits.
- DIGITS, 2, number of displayed decimal digits. Must satisfy 10^DIGITS > 2^(W+1)-1.
- SCAN_DIV, 50000, clock cycles per digit slot. Must be ≥ 2.

Ports:
- clk  in  1  system clock; the single clock for all logic.
- rst_n  in  1  synchronous, active-low reset, sampled on the rising edge of clk.
- din_a  in  W  operand A.
- din_b  in  W  operand B.
- load  in  1  start strobe; sampled only in IDLE.
- busy  out  1  conversion in progress.
- done  out  1  one-cycle pulse when the display value updates.
- seg_n  out  7  active-low segments; seg_n[0]=a … seg_n[6]=g.
- dp_n  out  1  decimal point; constant 1 (off).
- an_n  out  DIGITS  active-low one-hot digit enable; an_n[0] is the least significant digit.

Behaviour:
- Reset (rst_n=0 at an edge):
  - state IDLE, busy=0, done=0.
  - display register = 0, scan index = 0, prescaler = 0.
  - an_n = all ones except bit 0 = 0.
  - seg_n = 7'b1000000 (digit '0'), dp_n = 1.
- Arithmetic: sum = din_a + din_b, zero-extended to W+1 bits; the carry is never lost.
- FSM IDLE:
  - load=1 at edge E0 → capture sum into the shift register, clear the BCD register, set iteration count = W+1, go to CONV, busy=1.
  - load=0 → stay in IDLE.
- FSM CONV, one iteration per edge:
  - add 3 to every BCD nibble ≥ 5;
  - shift {bcd, bin} left by 1;
  - decrement the count.
- Conversion end:
  - The iteration at edge E(W+1) is the last.
  - At that edge the post-iteration BCD is written directly into the display register.
  - At the same edge: done ← 1 for exactly one cycle, busy ← 0, state ← IDLE.
- Latency: busy is high for exactly W+1 cycles (5 for W=4); the display changes at edge E(W+1).
- load while busy: ignored, not queued.
- load held high: a new conversion starts on the IDLE cycle that carries the done pulse.
- Operands are sampled only at E0; later changes do not affect the conversion in flight.
- Display register holds its old value throughout a conversion, so there is no flicker of partial results.
- Scan:
  - The prescaler counts 0..SCAN_DIV-1 and wraps.
  - On each wrap the scan index increments, wrapping DIGITS-1 → 0.
  - an_n and seg_n are registered: they reflect the new index one cycle after the index change.
- Decode: BCD 0–9 use the standard active-low patterns; values 10–15 are impossible and decode to blank (7'h7F).
- Reset mid-conversion: the conversion is aborted, outputs return to reset values, and no done pulse is produced.

Optional Feature:
- Macro: LEADING_ZERO_BLANK_EN.
- Defined: any digit above the most significant nonzero digit outputs seg_n=7'h7F while its an_n bit is still driven. Digit 0 is never blanked, so a value of 0 shows a single '0'.
- Undefined: all digits are always shown, with leading zeros.

Decomposition:
- Package adder_bcd_pkg holds:
  - state enum {IDLE, CONV};
  - SEG_BLANK = 7'h7F;
  - the ten active-low digit constants (0=1000000, 1=1111001, 2=0100100, 3=0110000, 4=0011001, 5=0010010, 6=0000010, 7=1111000, 8=0000000, 9=0010000);
  - function bcd_width(W).
- One sub-module: bcd_seg_decode (4-bit BCD in, blank flag in, 7-bit seg_n out; combinational).
- Instantiated once, on the scanned digit.

Test Plan (W=4, DIGITS=2, SCAN_DIV=4):
- Reset: hold rst_n=0 for 2 cycles, then release → busy=0, done=0, an_n=2'b10, seg_n=7'b1000000, dp_n=1. an_n becomes 2'b01 about 4 cycles later.
- Normal add: din_a=9, din_b=8, load pulse → busy=1 for 5 cycles, done pulse on the 6th. Slot 0 shows seg_n=7'b1111000 ('7'); slot 1 shows 7'b1111001 ('1').
- Max carry: din_a=15, din_b=15 → display 30. Digit0=7'b1000000, digit1=7'b0110000.
- load while busy: start 9+8, then pulse load with 1+1 at cycle 2 of busy → result 17, exactly one done pulse.
- Abort: start 15+15, assert rst_n=0 in the 3rd busy cycle → no done pulse, display reads 00 (or blank+0 with LEADING_ZERO_BLANK_EN).
- Blanking: din_a=2, din_b=3 → digit0 '5' (7'b0010010). Digit1 = 7'h7F with LEADING_ZERO_BLANK_EN, 7'b1000000 without.
